// File: rtl/key_schedule_pkg.sv
// Shared types and constants for the round-key expansion block.
package key_schedule_pkg;

  localparam int KEY_W   = 16;
  localparam int ROT_AMT = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  function automatic logic [KEY_W-1:0] rotl(input logic [KEY_W-1:0] v);
    return {v[KEY_W-1-ROT_AMT:0], v[KEY_W-1 -: ROT_AMT]};
  endfunction

endpackage

// File: rtl/key_round_fn.sv
// Combinational round function: next round key from the previous key and its round number.
module key_round_fn
  import key_schedule_pkg::*;
(
  input  logic [KEY_W-1:0] rk_prev,
  input  logic [7:0]       round,
  output logic [KEY_W-1:0] rk_next
);

  logic [7:0] w_rc;

  assign w_rc    = round + 8'h01;
  assign rk_next = rotl(rk_prev) ^ {8'h00, w_rc};

endmodule

// File: rtl/key_schedule.sv
// Expands a 16-bit key into ROUNDS round keys (one per clock) and serves them by index.
// state  | meaning
// IDLE   | no valid keys, reads rejected
// EXPAND | generating rk[cnt] from rk[cnt-1] each cycle
// READY  | full round-key file valid, reads served
module key_schedule
  import key_schedule_pkg::*;
#(
  parameter int ROUNDS = 8,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  input  logic             zeroize,
  output logic             busy,
  output logic             keys_ready,
  input  logic             rk_req,
  input  logic [IDX_W-1:0] rk_idx,
  output logic [KEY_W-1:0] rk_out,
  output logic             rk_valid,
  output logic             rk_err
);

  localparam int               AW        = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
  localparam logic [IDX_W-1:0] LP_LAST   = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W:0]   LP_ROUNDS = (IDX_W + 1)'(ROUNDS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_prev_idx;
  logic [KEY_W-1:0] r_rk [ROUNDS];
  logic [KEY_W-1:0] w_rk_prev;
  logic [KEY_W-1:0] w_rk_next;
  logic [KEY_W-1:0] r_rk_out;
  logic             r_rk_valid;
  logic             r_rk_err;
  logic             w_rd_ok;
  logic             w_last;

  assign w_prev_idx = r_cnt - IDX_W'(1);
  assign w_last     = (r_cnt == LP_LAST);
  // cnt is 0 only outside EXPAND, where the round function output is unused
  assign w_rk_prev  = ({1'b0, w_prev_idx} < LP_ROUNDS) ? r_rk[w_prev_idx[AW-1:0]] : '0;
  assign w_rd_ok    = (r_state == ST_READY) && ({1'b0, rk_idx} < LP_ROUNDS);

  key_round_fn u_round_fn (
    .rk_prev (w_rk_prev),
    .round   (8'(w_prev_idx)),
    .rk_next (w_rk_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (zeroize) begin
      w_state_nxt = ST_IDLE;
    end else if (key_load) begin
      w_state_nxt = ST_EXPAND;
    end else begin
      case (r_state)
        ST_EXPAND: if (w_last) w_state_nxt = ST_READY;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_rk_out   <= '0;
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
      for (int i = 0; i < ROUNDS; i++) r_rk[i] <= '0;
    end else begin
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
      if (zeroize) begin
        r_cnt    <= '0;
        r_rk_out <= '0;
        r_rk_err <= rk_req;
        for (int i = 0; i < ROUNDS; i++) r_rk[i] <= '0;
      end else if (key_load) begin
        // a read colliding with a load is rejected: the key file is being replaced
        r_rk[0]  <= key_in;
        r_cnt    <= IDX_W'(1);
        r_rk_err <= rk_req;
      end else begin
        if (r_state == ST_EXPAND) begin
          r_rk[r_cnt[AW-1:0]] <= w_rk_next;
          if (!w_last) r_cnt <= r_cnt + IDX_W'(1);
        end
        if (rk_req) begin
          if (w_rd_ok) begin
            r_rk_out   <= r_rk[rk_idx[AW-1:0]];
            r_rk_valid <= 1'b1;
          end else begin
            r_rk_err   <= 1'b1;
          end
        end
      end
    end
  end

  assign busy       = (r_state == ST_EXPAND);
  assign keys_ready = (r_state == ST_READY);
  assign rk_out     = r_rk_out;
  assign rk_valid   = r_rk_valid;
  assign rk_err     = r_rk_err;

endmodule

// File: tb/tb_key_schedule.sv
// Directed bench for key_schedule: table-driven reads plus hand-written abort/zeroize/reset sequences.
module tb_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] key_in = '0;
  logic        key_load = 1'b0;
  logic        zeroize = 1'b0;
  logic        busy;
  logic        keys_ready;
  logic        rk_req = 1'b0;
  logic [3:0]  rk_idx = '0;
  logic [15:0] rk_out;
  logic        rk_valid;
  logic        rk_err;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  idx;
    logic        exp_valid;
    logic [15:0] exp_out;
  } rd_vec_t;

  rd_vec_t vec [10];

  key_schedule #(.ROUNDS(8), .IDX_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_load   (key_load),
    .zeroize    (zeroize),
    .busy       (busy),
    .keys_ready (keys_ready),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_out     (rk_out),
    .rk_valid   (rk_valid),
    .rk_err     (rk_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic read1(input string nm, input logic [3:0] idx, input logic ev, input logic [15:0] eo);
    rk_idx = idx;
    rk_req = 1'b1;
    tick();
    rk_req = 1'b0;
    chk1({nm, "_valid"}, rk_valid, ev);
    chk1({nm, "_err"}, rk_err, ~ev);
    chk16({nm, "_out"}, rk_out, eo);
  endtask

  function automatic logic [15:0] mdl(input logic [15:0] k, input int r);
    logic [15:0] x;
    x = k;
    for (int i = 0; i < r; i++) x = ((x << 3) | (x >> 13)) ^ 16'(i + 1);
    return x;
  endfunction

  initial begin
    int n;

    vec[0] = '{4'd0,  1'b1, 16'h0001};
    vec[1] = '{4'd1,  1'b1, 16'h0009};
    vec[2] = '{4'd2,  1'b1, 16'h004A};
    vec[3] = '{4'd3,  1'b1, 16'h0253};
    vec[4] = '{4'd8,  1'b0, 16'h0253};
    vec[5] = '{4'd4,  1'b1, 16'h129C};
    vec[6] = '{4'd5,  1'b1, 16'h94E5};
    vec[7] = '{4'd6,  1'b1, 16'hA72A};
    vec[8] = '{4'd7,  1'b1, 16'h3952};
    vec[9] = '{4'd15, 1'b0, 16'h3952};

    // reset state
    #12;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", keys_ready, 1'b0);
    chk16("rst_out", rk_out, 16'h0000);
    chk1("rst_valid", rk_valid, 1'b0);
    chk1("rst_err", rk_err, 1'b0);
    rst = 1'b1;
    tick();

    // 1: expand key 0001, busy for 7 cycles, back-to-back table reads
    load(16'h0001);
    chk1("t1_busy0", busy, 1'b1);
    chk1("t1_ready0", keys_ready, 1'b0);
    wait_ready(n);
    chk_int("t1_busy_cycles", n, 7);
    chk1("t1_ready", keys_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      rk_idx = vec[i].idx;
      rk_req = 1'b1;
      tick();
      chk1($sformatf("t1_valid[%0d]", i), rk_valid, vec[i].exp_valid);
      chk1($sformatf("t1_err[%0d]", i), rk_err, ~vec[i].exp_valid);
      chk16($sformatf("t1_out[%0d]", i), rk_out, vec[i].exp_out);
    end
    rk_req = 1'b0;
    tick();
    chk1("t1_valid_pulse", rk_valid, 1'b0);
    chk1("t1_err_pulse", rk_err, 1'b0);

    // 2: request during EXPAND and out-of-range index in READY
    load(16'hA5C3);
    read1("t2_expand_req", 4'd0, 1'b0, 16'h3952);
    wait_ready(n);
    chk_int("t2_busy_rest", n, 6);
    chk1("t2_ready", keys_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rk_idx = 4'(i);
      rk_req = 1'b1;
      tick();
      chk1($sformatf("t2_valid[%0d]", i), rk_valid, 1'b1);
      chk16($sformatf("t2_out[%0d]", i), rk_out, mdl(16'hA5C3, i));
    end
    rk_req = 1'b0;
    read1("t2_idx8", 4'd8, 1'b0, mdl(16'hA5C3, 7));

    // 3: abort an expansion with a new load
    load(16'hFFFF);
    tick();
    tick();
    chk1("t3_busy_mid", busy, 1'b1);
    load(16'h0001);
    chk1("t3_busy_restart", busy, 1'b1);
    wait_ready(n);
    chk_int("t3_busy_cycles", n, 7);
    read1("t3_rk1", 4'd1, 1'b1, 16'h0009);
    read1("t3_rk7", 4'd7, 1'b1, 16'h3952);

    // 4: zeroize wins over a concurrent load
    zeroize  = 1'b1;
    key_in   = 16'h1234;
    key_load = 1'b1;
    tick();
    zeroize  = 1'b0;
    key_load = 1'b0;
    chk1("t4_ready", keys_ready, 1'b0);
    chk1("t4_busy", busy, 1'b0);
    chk16("t4_out", rk_out, 16'h0000);
    read1("t4_req0", 4'd0, 1'b0, 16'h0000);
    read1("t4_req3", 4'd3, 1'b0, 16'h0000);
    chk1("t4_still_idle", busy, 1'b0);

    // 5: load and read on the same edge
    load(16'h0001);
    wait_ready(n);
    chk_int("t5_busy_cycles", n, 7);
    read1("t5_rk1", 4'd1, 1'b1, 16'h0009);
    rk_idx   = 4'd2;
    rk_req   = 1'b1;
    key_in   = 16'h0001;
    key_load = 1'b1;
    tick();
    rk_req   = 1'b0;
    key_load = 1'b0;
    chk1("t5_err", rk_err, 1'b1);
    chk1("t5_valid", rk_valid, 1'b0);
    chk1("t5_busy", busy, 1'b1);
    chk16("t5_out_hold", rk_out, 16'h0009);

    // 6: asynchronous reset mid-expansion
    tick();
    tick();
    chk1("t6_busy_pre", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_ready", keys_ready, 1'b0);
    chk16("t6_out", rk_out, 16'h0000);
    chk1("t6_valid", rk_valid, 1'b0);
    chk1("t6_err", rk_err, 1'b0);
    #1;
    rst = 1'b1;
    read1("t6_req0", 4'd0, 1'b0, 16'h0000);
    chk1("t6_ready_post", keys_ready, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
